// File: rtl/pa_ifu_tagram_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pa_ifu_tagram_ctrl_pkg                                        |
// | Desc   : Shared sizes and FSM encoding for the IFU tag-RAM controller |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package pa_ifu_tagram_ctrl_pkg;

    localparam int c_addr_width = 7;
    localparam int c_data_width = 43;
    localparam int c_entries    = 128;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INV  = 1'b1
    } tagram_state_e;

endpackage : pa_ifu_tagram_ctrl_pkg
`default_nettype wire

// File: rtl/pa_ifu_tagram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pa_ifu_tagram_ctrl                                            |
// | Desc   : Tag-RAM port arbiter (refill > read) with invalidate sweep;   |
// |          PA_TAGRAM_PARITY_EN adds even parity in the top data bit.     |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module pa_ifu_tagram_ctrl
    import pa_ifu_tagram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  inv_req,
    output logic                  inv_busy,
    output logic                  inv_done,
    input  logic                  rfl_req,
    input  logic [ADDR_WIDTH-1:0] rfl_addr,
    input  logic [DATA_WIDTH-1:0] rfl_data,
    output logic                  rfl_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_par_err,
    output logic                  ram_cen,
    output logic                  ram_gwen,
    output logic [DATA_WIDTH-1:0] ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    tagram_state_e         r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_inv_done;
    logic                  r_rd_vld;
    logic [ADDR_WIDTH-1:0] r_a_hold;
    logic [DATA_WIDTH-1:0] r_d_hold;

    logic                  w_inv;
    logic                  w_idle;
    logic                  w_sweep_start;
    logic                  w_rfl_gnt;
    logic                  w_rd_gnt;
    logic                  w_wr;
    logic                  w_access;
    logic [DATA_WIDTH-1:0] w_rfl_word;
    logic [ADDR_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_d;

    // Grants are masked while reset is low so the SRAM stays deselected.
    assign w_inv         = (r_state == INV);
    assign w_idle        = (r_state == IDLE) && cpurst_b;
    assign w_sweep_start = w_idle && inv_req;
    assign w_rfl_gnt     = w_idle && !inv_req && rfl_req;
    assign w_rd_gnt      = w_idle && !inv_req && !rfl_req && rd_req;
    assign w_wr          = w_inv || w_rfl_gnt;
    assign w_access      = w_wr || w_rd_gnt;

`ifdef PA_TAGRAM_PARITY_EN
    assign w_rfl_word = {^rfl_data[DATA_WIDTH-2:0], rfl_data[DATA_WIDTH-2:0]};
    assign rd_par_err = r_rd_vld && (^ram_q);
`else
    assign w_rfl_word = rfl_data;
    assign rd_par_err = 1'b0;
`endif

    always_comb begin
        w_a = r_a_hold;
        w_d = r_d_hold;
        if (w_inv) begin
            w_a = r_cnt;
            w_d = '0;
        end else if (w_rfl_gnt) begin
            w_a = rfl_addr;
            w_d = w_rfl_word;
        end else if (w_rd_gnt) begin
            w_a = rd_addr;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_inv_done <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_a_hold   <= '0;
            r_d_hold   <= '0;
        end else begin
            r_inv_done <= w_inv && (&r_cnt);
            r_rd_vld   <= w_rd_gnt;
            if (w_access) begin
                r_a_hold <= w_a;
                r_d_hold <= w_d;
            end
            case (r_state)
                IDLE: begin
                    if (w_sweep_start) begin
                        r_state <= INV;
                        r_cnt   <= '0;
                    end
                end
                INV: begin
                    if (&r_cnt) begin
                        r_state <= IDLE;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inv_busy = w_inv;
    assign inv_done = r_inv_done;
    assign rfl_gnt  = w_rfl_gnt;
    assign rd_gnt   = w_rd_gnt;
    assign rd_vld   = r_rd_vld;
    assign rd_data  = ram_q;
    assign ram_cen  = !w_access;
    assign ram_gwen = !w_wr;
    assign ram_wen  = {DATA_WIDTH{!w_wr}};
    assign ram_a    = w_a;
    assign ram_d    = w_d;

endmodule : pa_ifu_tagram_ctrl
`default_nettype wire

// File: doc/pa_ifu_tagram_ctrl.md
PA_IFU_TAGRAM_CTRL -- requirements
Module: pa_ifu_tagram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, SRAM address width (128 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 43, SRAM word width.
REQ-003 SHALL have port forever_cpuclk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port cpurst_b  input  1  asynchronous active-low reset.
REQ-005 SHALL have port inv_req  input  1  start invalidate-all sweep (level, sampled in IDLE).
REQ-006 SHALL have port inv_busy  output  1  sweep in progress.
REQ-007 SHALL have port inv_done  output  1  one-cycle pulse at sweep completion.
REQ-008 SHALL have ports rfl_req input 1, rfl_addr input 7, rfl_data input 43, rfl_gnt output 1  refill write request, address, data and grant.
REQ-009 SHALL have ports rd_req input 1, rd_addr input 7, rd_gnt output 1  lookup read request, address and grant.
REQ-010 SHALL have ports rd_vld output 1, rd_data output 43, rd_par_err output 1  read return.
REQ-011 SHALL have ports ram_cen, ram_gwen output 1; ram_wen output 43; ram_a output 7; ram_d output 43; ram_q input 43  SRAM side; CEN, GWEN and WEN are active-low.

Function
REQ-012 SHALL implement states IDLE and INV; IDLE->INV when inv_req=1 in IDLE; INV->IDLE on the cycle writing address 127.
REQ-013 SHALL, in INV, write all-zero data to address = sweep counter, with counter 0..127 incrementing by one per cycle; CEN=0, GWEN=0, WEN=all 0.
REQ-014 SHALL hold inv_busy=1 for exactly 128 cycles and pulse inv_done=1 in the first IDLE cycle after the sweep.
REQ-015 SHALL ignore inv_req while in INV, and shall not auto-restart a sweep if inv_req is still high in that cycle's IDLE only after inv_done (inv_req must be level-sampled again in IDLE).
REQ-016 SHALL, in IDLE, use fixed priority refill > read; grants are combinational, same cycle as request.
REQ-017 SHALL force rfl_gnt=0 and rd_gnt=0 in INV and in the IDLE cycle where inv_req=1 (sweep wins).
REQ-018 SHALL, on a refill grant, drive CEN=0, GWEN=0, WEN=all 0, A=rfl_addr, D=refill word (see REQ-025).
REQ-019 SHALL, on a read grant, drive CEN=0, GWEN=1, WEN=all 1, A=rd_addr.
REQ-020 SHALL assert rd_vld exactly one cycle after rd_gnt, with rd_data=ram_q; no other cycle has rd_vld=1.
REQ-021 SHALL return new data for a read granted the cycle after a refill to the same address.
REQ-022 SHALL, with no grant and not INV, drive CEN=1, GWEN=1, WEN=all 1; A and D hold their last values.
REQ-023 SHALL keep an ungranted requester unaffected; requesters hold req/addr/data until granted.

Reset
REQ-024 SHALL, on cpurst_b=0, immediately go to IDLE, counter=0, inv_busy=0, inv_done=0, rd_vld=0, rd_par_err=0, CEN=1; a sweep aborted by reset does not pulse inv_done and is not resumed.

Configuration
REQ-025 SHALL, with PA_TAGRAM_PARITY_EN defined, write bit 42 as even parity of bits [41:0] (refill word = {^rfl_data[41:0], rfl_data[41:0]}), and assert rd_par_err with rd_vld when stored parity mismatches ram_q[41:0]; sweep writes parity 0 (valid for zero data).
REQ-026 SHALL, without PA_TAGRAM_PARITY_EN, write rfl_data unmodified and tie rd_par_err to 0.

Structure
REQ-027 SHALL place ADDR_WIDTH, DATA_WIDTH, entry count 128 and the state encoding (IDLE=1'b0, INV=1'b1) in a shared package.
REQ-028 SHALL instantiate no sub-module; pa_spsram_128x43 is instantiated by the parent alongside this block.

Verification
REQ-029 SHALL cover: reset, pulse inv_req one cycle -> inv_busy high 128 cycles, addresses 0..127 written zero, inv_done pulse on cycle 129.
REQ-030 SHALL cover: rfl_req and rd_req same IDLE cycle, addr 0x05 -> rfl_gnt=1, rd_gnt=0; next cycle rd_gnt=1; following cycle rd_vld=1 with refilled data.
REQ-031 SHALL cover: rd_req during INV -> rd_gnt=0 until first IDLE cycle, then granted; rd_vld one cycle later.
REQ-032 SHALL cover: cpurst_b low at sweep counter 60 -> CEN=1 immediately, no inv_done; after release, read of addr 100 returns prior content.
REQ-033 SHALL cover (PARITY_EN): refill 0x001_0000_0001 at addr 3, flip bit 0 in the SRAM model, read addr 3 -> rd_vld=1, rd_par_err=1; unflipped read -> rd_par_err=0.
